fetch_stage: RTL and testbench

Instruction-fetch stage for the 5-stage pipelined CPU. It owns the program counter, issues word reads to the instruction memory over a request/acknowledge handshake, and buffers returned instructions in a 2-entry queue. The queue head drives the IF/ID pipeline register outputs that the ID stage (Control, Registers, Sign_Extend) consumes. It supports hazard stalls and branch/jump redirects with flush.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: the fetch stage drives request/address, memory
// answers with a same-cycle acknowledge and data word.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and buffers
// returned words in a small queue whose head feeds the IF/ID register outputs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  fetch_stage_if.master imem,
  output logic          ifid_valid_o,
  output logic [31:0]   ifid_pc_o,
  output logic [31:0]   ifid_pcplus4_o,
  output logic [31:0]   ifid_inst_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      pc;
  logic [31:0]      q_pc   [DEPTH];
  logic [31:0]      q_inst [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             req;
  logic             push;
  logic             pop;
  logic [31:0]      redirect_target;

  assign req             = start_i && rst_i && (count < FULL);
  assign push            = req && imem.imem_ack && !redirect_i;
  assign pop             = ifid_valid_o && !stall_i && !redirect_i;
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  // Redirect wins over push/pop: the queue is flushed and same-cycle ack data dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      pc     <= redirect_target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset; entries are only visible while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_pc[wr_ptr]   <= pc;
      q_inst[wr_ptr] <= imem.imem_data;
    end
  end

  always_comb begin
    ifid_valid_o   = (count != '0);
    ifid_pc_o      = '0;
    ifid_inst_o    = '0;
    if (ifid_valid_o) begin
      ifid_pc_o   = q_pc[rd_ptr];
      ifid_inst_o = q_inst[rd_ptr];
    end
    ifid_pcplus4_o = ifid_pc_o + 32'd4;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a queue-based program-order model
// predicts every delivered instruction and the memory request behaviour.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ack_r = 1'b0;
  int          mode = 0;
  int          wcnt = 0;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pcplus4;
  logic [31:0] ifid_inst;

  exp_t        exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  bit          check_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .stall_i        (stall),
    .redirect_i     (redirect),
    .redirect_pc_i  (redirect_pc),
    .imem           (imem_bus),
    .ifid_valid_o   (ifid_valid),
    .ifid_pc_o      (ifid_pc),
    .ifid_pcplus4_o (ifid_pcplus4),
    .ifid_inst_o    (ifid_inst)
  );

  always #5 clk = ~clk;

  assign imem_bus.imem_ack  = ack_r;
  assign imem_bus.imem_data = imem_bus.imem_addr ^ 32'hA5A5_0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit st, input bit rd,
                               input logic [31:0] tgt, input int m, input int n);
    rst         = r;
    start       = s;
    stall       = st;
    redirect    = rd;
    redirect_pc = tgt;
    mode        = m;
    repeat (n) @(negedge clk);
  endtask

  // Memory responder: zero-wait, two wait states, or random acknowledge.
  always @(negedge clk) begin
    #1;
    case (mode)
      0:       ack_r = imem_bus.imem_req;
      1:       ack_r = imem_bus.imem_req && (wcnt >= 2);
      default: ack_r = imem_bus.imem_req && ($urandom_range(0, 1) == 1);
    endcase
  end

  // Reference model: program-order PC plus a queue of fetched-but-unconsumed words.
  initial begin
    bit req_m;
    forever begin
      @(posedge clk);
      req_m = start && rst && (exp_q.size() < DEPTH);
      if (!rst || redirect || !req_m || ack_r) wcnt = 0;
      else wcnt++;
      if (!rst) begin
        exp_q.delete();
        model_pc = RESET_PC;
      end else if (redirect) begin
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (exp_q.size() != 0 && !stall) void'(exp_q.pop_front());
        if (req_m && ack_r) begin
          exp_q.push_back('{pc: model_pc, inst: model_pc ^ 32'hA5A5_0000});
          model_pc = model_pc + 32'd4;
        end
      end
      check_en = 1'b1;
    end
  end

  // Monitor: compares the presented head and request port against the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (check_en) begin
        checkOutput("valid", {31'd0, ifid_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() == 0) begin
          checkOutput("empty_inst", ifid_inst, 32'h0);
          checkOutput("empty_pc", ifid_pc, 32'h0);
          checkOutput("empty_pcplus4", ifid_pcplus4, 32'h4);
        end else begin
          checkOutput("head_pc", ifid_pc, exp_q[0].pc);
          checkOutput("head_inst", ifid_inst, exp_q[0].inst);
          checkOutput("head_pcplus4", ifid_pcplus4, exp_q[0].pc + 32'd4);
        end
        checkOutput("imem_req", {31'd0, imem_bus.imem_req},
                    {31'd0, start && rst && (exp_q.size() < DEPTH)});
        if (start && rst && (exp_q.size() < DEPTH))
          checkOutput("imem_addr", imem_bus.imem_addr, model_pc);
      end
    end
  end

  initial begin
    @(negedge clk);
    // Reset held three cycles, then zero-wait fetch from RESET_PC.
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 3);
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 10);
    // Two wait states per request.
    applyStimulus(1, 1, 0, 1, 32'h0, 1, 1);
    applyStimulus(1, 1, 0, 0, 32'h0, 1, 15);
    // Stall fill near pc 8, then release.
    applyStimulus(1, 1, 0, 1, 32'h0, 0, 1);
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 2);
    applyStimulus(1, 1, 1, 0, 32'h0, 0, 5);
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 6);
    // Redirect with stall and ack in the same cycle; target low bits ignored.
    applyStimulus(1, 1, 1, 1, 32'h0000_0103, 0, 1);
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 6);
    // PC wrap through the top of the address space.
    applyStimulus(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 1);
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 6);
    // start low drains the queue, pc holds.
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 4);
    // Reset mid-run with a full queue and a request outstanding.
    applyStimulus(1, 1, 1, 0, 32'h0, 1, 4);
    applyStimulus(0, 1, 1, 0, 32'h0, 1, 1);
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 6);
    // Random mix of stalls, redirects, start gaps, resets and ack timing.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 99) != 0,
                    $urandom_range(0, 9) != 0,
                    $urandom_range(0, 9) < 3,
                    $urandom_range(0, 19) == 0,
                    $urandom(),
                    int'($urandom_range(0, 2)),
                    1);
    end
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
